// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage: control-word field indices,
// access-size encodings, FSM states and the byte-lane helpers.
package mips_pkg;

    localparam int CTRL_MEM_RD  = 0;
    localparam int CTRL_MEM_WR  = 1;
    localparam int CTRL_REG_WR  = 2;
    localparam int CTRL_SIZE_LO = 3;
    localparam int CTRL_SIZE_HI = 4;
    localparam int CTRL_LD_UNS  = 5;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Little-endian byte enables; shared by the load and store paths.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] b);
        logic [31:0] w;
        case (size)
            SIZE_BYTE: w = {4{b[7:0]}};
            SIZE_HALF: w = {2{b[15:0]}};
            default:   w = b;
        endcase
        return w;
    endfunction

    // Bytes are always aligned; an unused size code is treated as a word.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SIZE_BYTE: ok = 1'b1;
            SIZE_HALF: ok = ~addr_lo[0];
            default:   ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half/word lane of the read data and applies
// sign or zero extension.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        ld_uns,
    output logic [31:0] data
);

    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    always_comb begin
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
    end

    always_comb begin
        case (size)
            SIZE_HALF: data = {{16{~ld_uns & half_lane[15]}}, half_lane};
            SIZE_BYTE: data = {{24{~ld_uns & byte_lane[7]}}, byte_lane};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: issues loads/stores over a
// req/ack port, stalls upstream while a transfer is in flight.
//
// state   | meaning
// IDLE    | no transfer outstanding; instructions pass or are accepted
// BUSY    | request on the bus, waiting for dmem_ack
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CTRL_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [31:0]       instruction_in,
    input  logic [CTRL_W-1:0] ctrl_msg_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       b_in,
    input  logic              flush,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_instruction,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [31:0]       wb_data,
    output logic              wb_misalign
);

    state_t state, nxt_state;
    logic   drop, nxt_drop;

    logic              nxt_req, nxt_we;
    logic [ADDR_W-1:0] nxt_addr;
    logic [3:0]        nxt_be;
    logic [31:0]       nxt_wdata;

    logic              nxt_wb_valid, nxt_wb_misalign;
    logic [31:0]       nxt_wb_instruction, nxt_wb_data;
    logic [CTRL_W-1:0] nxt_wb_ctrl;

    logic [31:0]       lat_instr, nxt_lat_instr;
    logic [CTRL_W-1:0] lat_ctrl, nxt_lat_ctrl;
    logic [31:0]       lat_addr, nxt_lat_addr;

    logic        in_mem, in_aligned;
    logic [1:0]  in_size;
    logic [31:0] load_data;

    assign in_size    = ctrl_msg_in[CTRL_SIZE_HI:CTRL_SIZE_LO];
    assign in_mem     = ctrl_msg_in[CTRL_MEM_RD] | ctrl_msg_in[CTRL_MEM_WR];
    assign in_aligned = is_aligned(in_size, alu_in[1:0]);

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (lat_addr[1:0]),
        .size    (lat_ctrl[CTRL_SIZE_HI:CTRL_SIZE_LO]),
        .ld_uns  (lat_ctrl[CTRL_LD_UNS]),
        .data    (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            drop           <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_be        <= '0;
            dmem_wdata     <= '0;
            wb_valid       <= 1'b0;
            wb_instruction <= '0;
            wb_ctrl        <= '0;
            wb_data        <= '0;
            wb_misalign    <= 1'b0;
            lat_instr      <= '0;
            lat_ctrl       <= '0;
            lat_addr       <= '0;
        end else begin
            state          <= nxt_state;
            drop           <= nxt_drop;
            dmem_req       <= nxt_req;
            dmem_we        <= nxt_we;
            dmem_addr      <= nxt_addr;
            dmem_be        <= nxt_be;
            dmem_wdata     <= nxt_wdata;
            wb_valid       <= nxt_wb_valid;
            wb_instruction <= nxt_wb_instruction;
            wb_ctrl        <= nxt_wb_ctrl;
            wb_data        <= nxt_wb_data;
            wb_misalign    <= nxt_wb_misalign;
            lat_instr      <= nxt_lat_instr;
            lat_ctrl       <= nxt_lat_ctrl;
            lat_addr       <= nxt_lat_addr;
        end
    end

    always_comb begin
        nxt_state          = state;
        nxt_drop           = drop;
        nxt_req            = dmem_req;
        nxt_we             = dmem_we;
        nxt_addr           = dmem_addr;
        nxt_be             = dmem_be;
        nxt_wdata          = dmem_wdata;
        nxt_wb_valid       = wb_valid;
        nxt_wb_instruction = wb_instruction;
        nxt_wb_ctrl        = wb_ctrl;
        nxt_wb_data        = wb_data;
        nxt_wb_misalign    = wb_misalign;
        nxt_lat_instr      = lat_instr;
        nxt_lat_ctrl       = lat_ctrl;
        nxt_lat_addr       = lat_addr;
        stall              = 1'b0;

        case (state)
            ST_IDLE: begin
                nxt_drop = 1'b0;
                if (!valid_in || flush) begin
                    nxt_wb_valid = 1'b0;
                end else if (!in_mem) begin
                    nxt_wb_valid       = 1'b1;
                    nxt_wb_instruction = instruction_in;
                    nxt_wb_ctrl        = ctrl_msg_in;
                    nxt_wb_data        = alu_in;
                    nxt_wb_misalign    = 1'b0;
                end else if (!in_aligned) begin
                    nxt_wb_valid       = 1'b1;
                    nxt_wb_instruction = instruction_in;
                    nxt_wb_ctrl        = ctrl_msg_in;
                    nxt_wb_ctrl[CTRL_REG_WR] = 1'b0;
                    nxt_wb_data        = alu_in;
                    nxt_wb_misalign    = 1'b1;
                end else begin
                    stall         = 1'b1;
                    nxt_state     = ST_BUSY;
                    nxt_req       = 1'b1;
                    nxt_we        = ctrl_msg_in[CTRL_MEM_WR];
                    nxt_addr      = {alu_in[ADDR_W-1:2], 2'b00};
                    nxt_be        = lane_be(in_size, alu_in[1:0]);
                    nxt_wdata     = store_wdata(in_size, b_in);
                    nxt_lat_instr = instruction_in;
                    nxt_lat_ctrl  = ctrl_msg_in;
                    nxt_lat_addr  = alu_in;
                    nxt_wb_valid  = 1'b0;
                end
            end
            ST_BUSY: begin
                if (dmem_ack) begin
                    nxt_state          = ST_IDLE;
                    nxt_req            = 1'b0;
                    nxt_drop           = 1'b0;
                    // A flush on the ack cycle itself also squashes the result.
                    nxt_wb_valid       = ~(drop | flush);
                    nxt_wb_instruction = lat_instr;
                    nxt_wb_ctrl        = lat_ctrl;
                    nxt_wb_data        = dmem_we ? lat_addr : load_data;
                    nxt_wb_misalign    = 1'b0;
                end else begin
                    stall = 1'b1;
                    if (flush)
                        nxt_drop = 1'b1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

endmodule
